// File: rtl/rpi_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpi_cap_pkg
// Description : Shared types and constants for the RPi video capture path:
//               capture FSM state encoding, pixel packing width, pixel-clock
//               divider width and the divider mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rpi_cap_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam int PIX_PER_BYTE = 8;
  localparam int DIV_W        = 4;

  // Divider mask for a 2-bit select: (2 << sel) - 1 -> 1/3/7/15
  function automatic logic [DIV_W-1:0] div_mask(input logic [1:0] sel);
    logic [DIV_W:0] m;
    m = ((DIV_W+1)'(2) << sel) - (DIV_W+1)'(1);
    return m[DIV_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : DEPTH-stage flop chain bringing one asynchronous input into
//               the clk domain. q is the last stage.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r_stage;

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], d};
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/rpi_video_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rpi_video_sampler
// Description : Capture front end for the SRAM recorder. Synchronises the RPi
//               h_sync/v_sync/color pins, samples color at a key-selected
//               division of clk, packs 8 pixels per byte (MSB = earliest) and
//               offers bytes on a valid/ready handshake. Also reports frame
//               start, active line count and a sticky byte-drop flag.
//               Build option: TEST_PATTERN_EN replaces the sampled pixel with
//               an 8x8 checkerboard (line_cnt[3] ^ pix_cnt[3]).
// Revision    : 1.0 - initial release
// ============================================================================
module rpi_video_sampler
  import rpi_cap_pkg::*;
#(
  parameter int LINE_W  = 10,
  parameter int SYNC_FF = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rpi_h_sync,
  input  logic              rpi_v_sync,
  input  logic              rpi_color,
  input  logic [1:0]        key,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_start,
  output logic [LINE_W-1:0] line_cnt,
  output logic              overflow
);

  // ---------------------------------------------------------------- sync
  logic [2:0] w_raw;
  logic [2:0] w_sync;
  logic       w_h_sync;
  logic       w_v_sync;
  logic       w_color;

  assign w_raw = {rpi_h_sync, rpi_v_sync, rpi_color};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    sync_ff #(.DEPTH(SYNC_FF)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (w_raw[gi]),
      .q     (w_sync[gi])
    );
  end

  assign w_h_sync = w_sync[2];
  assign w_v_sync = w_sync[1];
  assign w_color  = w_sync[0];

  logic r_h_prev;
  logic r_v_prev;

  // One extra delay on the synced syncs for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_prev <= 1'b0;
      r_v_prev <= 1'b0;
    end else begin
      r_h_prev <= w_h_sync;
      r_v_prev <= w_v_sync;
    end
  end

  logic w_h_rise;
  logic w_v_rise;
  logic w_v_fall;

  assign w_h_rise = w_h_sync & ~r_h_prev;
  assign w_v_rise = w_v_sync & ~r_v_prev;
  assign w_v_fall = ~w_v_sync & r_v_prev;

  // ------------------------------------------------------------- divider
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_div_sel;
  logic [DIV_W-1:0] w_mask;
  logic             w_tick;

  // Free-running divider; the rate select only changes at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_div_sel <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      if (w_v_rise) begin
        r_div_sel <= key;
      end
    end
  end

  assign w_mask = div_mask(r_div_sel);
  assign w_tick = ((r_div_cnt & w_mask) == w_mask);

  // ----------------------------------------------------------------- FSM
  state_t            r_state;
  logic              r_frame_start;
  logic [LINE_W-1:0] r_line_cnt;

  logic w_line_end;
  logic w_sample;

  assign w_line_end = (r_state == S_ACTIVE) && w_h_rise;
  assign w_sample   = (r_state == S_ACTIVE) && !w_h_sync && w_tick;

  // Frame/line tracking; the first partial frame after reset is skipped in S_IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_frame_start <= 1'b0;
      r_line_cnt    <= '0;
    end else begin
      r_frame_start <= w_v_rise;
      case (r_state)
        S_IDLE:   if (w_v_rise) r_state <= S_VBLANK;
        S_VBLANK: if (w_v_fall) r_state <= S_ACTIVE;
        S_ACTIVE: if (w_v_rise) r_state <= S_VBLANK;
        default:  r_state <= S_IDLE;
      endcase
      if (w_v_rise) begin
        r_line_cnt <= '0;
      end else if (w_line_end && (r_line_cnt != '1)) begin
        r_line_cnt <= r_line_cnt + LINE_W'(1);
      end
    end
  end

  // -------------------------------------------------------- pixel source
  logic w_bit;

`ifdef TEST_PATTERN_EN
  logic [3:0] r_pix_cnt;

  // Pixel position within the line, drives the checkerboard column phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
    end else if (w_v_rise || w_line_end) begin
      r_pix_cnt <= '0;
    end else if (w_sample) begin
      r_pix_cnt <= r_pix_cnt + 4'd1;
    end
  end

  assign w_bit = r_line_cnt[3] ^ r_pix_cnt[3];
`else
  assign w_bit = w_color;
`endif

  // ------------------------------------------------------- byte assembly
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] w_shift_nxt;
  logic [2:0] w_bit_cnt_nxt;
  logic       w_byte_done;
  logic [7:0] w_byte;
  logic [3:0] w_pad;

  assign w_pad = 4'(PIX_PER_BYTE) - {1'b0, r_bit_cnt};

  // Next shift state and completed byte; frame start beats line end beats sample
  always_comb begin
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_byte_done   = 1'b0;
    w_byte        = '0;
    if (w_v_rise) begin
      w_shift_nxt   = '0;
      w_bit_cnt_nxt = '0;
    end else if (w_line_end) begin
      if (r_bit_cnt != 3'd0) begin
        w_byte_done = 1'b1;
        w_byte      = r_shift << w_pad;
      end
      w_shift_nxt   = '0;
      w_bit_cnt_nxt = '0;
    end else if (w_sample) begin
      w_shift_nxt   = {r_shift[6:0], w_bit};
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) begin
        w_byte_done = 1'b1;
        w_byte      = {r_shift[6:0], w_bit};
      end
    end
  end

  // Register the shift register and its bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // ------------------------------------------------------ output handshake
  logic [7:0] r_pix_data;
  logic       r_pix_valid;
  logic       r_overflow;
  logic       w_can_load;
  logic       w_drop;

  assign w_can_load = !r_pix_valid || pix_ready;
  assign w_drop     = w_byte_done && !w_can_load;

  // Output byte is frozen while stalled; a byte finishing then is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_byte_done && w_can_load) begin
        r_pix_data  <= w_byte;
        r_pix_valid <= 1'b1;
      end else if (r_pix_valid && pix_ready) begin
        r_pix_valid <= 1'b0;
      end
      if (w_v_rise) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign pix_data    = r_pix_data;
  assign pix_valid   = r_pix_valid;
  assign frame_start = r_frame_start;
  assign line_cnt    = r_line_cnt;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rpi_video_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpi_video_sampler
// Description : Directed, table-driven bench for rpi_video_sampler. Inputs are
//               driven on the falling edge; a small divider model predicts
//               which driven color value lands on a pixel tick.
//               Build option: TEST_PATTERN_EN selects the checkerboard tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rpi_video_sampler;

  localparam int LINE_W  = 10;
  localparam int SYNC_FF = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rpi_h_sync;
  logic              rpi_v_sync;
  logic              rpi_color;
  logic [1:0]        key;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              frame_start;
  logic [LINE_W-1:0] line_cnt;
  logic              overflow;

  always #5 clk = ~clk;

  rpi_video_sampler #(.LINE_W(LINE_W), .SYNC_FF(SYNC_FF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rpi_h_sync  (rpi_h_sync),
    .rpi_v_sync  (rpi_v_sync),
    .rpi_color   (rpi_color),
    .key         (key),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_start (frame_start),
    .line_cnt    (line_cnt),
    .overflow    (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Divider model: free 4-bit count from reset, rate chosen at each frame
  logic [3:0] mcnt;
  logic [1:0] tb_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 4'd0;
    else        mcnt <= mcnt + 4'd1;
  end

  // True when inputs driven now reach the sampler on a pixel tick
  function automatic logic tick_at();
    logic [3:0] c;
    logic [4:0] m;
    c = mcnt + 4'(SYNC_FF);
    m = (5'd2 << tb_sel) - 5'd1;
    return (c & m[3:0]) == m[3:0];
  endfunction

  // Byte/frame monitor, sampled just after the falling edge
  logic [7:0] got[$];
  int         fs_seen = 0;

  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (pix_valid && pix_ready) got.push_back(pix_data);
      if (frame_start) fs_seen++;
    end
  end

  task automatic frame(input logic [1:0] k);
    int fs0;
    fs0 = fs_seen;
    @(negedge clk);
    key = k; tb_sel = k; rpi_h_sync = 1'b1; rpi_v_sync = 1'b1;
    repeat (6) @(negedge clk);
    rpi_v_sync = 1'b0;
    repeat (6) @(negedge clk);
    check("frame_start_pulse", fs_seen - fs0, 1);
  endtask

  // Drive h_sync low and present n pattern bits, MSB first, one per tick
  task automatic run_line(input int n, input logic [15:0] pat);
    int i;
    i = 0;
    while (i < n) begin
      @(negedge clk);
      rpi_h_sync = 1'b0;
      rpi_v_sync = 1'b0;
      if (tick_at()) begin
        rpi_color = pat[n-1-i];
        i++;
      end
    end
  endtask

  task automatic end_line();
    @(negedge clk);
    rpi_h_sync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  key;
    logic [1:0]  key_mid;
    int          nbits;
    logic [15:0] pat;
    int          nexp;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bad;
    vecs[0] = '{2'd0, 2'd0, 8,  16'h00B2, 1, 8'hB2, 8'h00};
    vecs[1] = '{2'd0, 2'd0, 12, 16'h0FFF, 2, 8'hFF, 8'hF0};
    vecs[2] = '{2'd1, 2'd1, 8,  16'h005A, 1, 8'h5A, 8'h00};
    vecs[3] = '{2'd3, 2'd0, 8,  16'h0096, 1, 8'h96, 8'h00};
    vecs[4] = '{2'd0, 2'd0, 3,  16'h0005, 1, 8'hA0, 8'h00};
    vecs[5] = '{2'd2, 2'd2, 5,  16'h001B, 1, 8'hD8, 8'h00};
    vecs[6] = '{2'd0, 2'd0, 16, 16'h00FF, 2, 8'h00, 8'hFF};

    rst_n = 1'b0; rpi_h_sync = 1'b1; rpi_v_sync = 1'b0; rpi_color = 1'b0;
    key = 2'd0; tb_sel = 2'd0; pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {pix_valid, frame_start, overflow, pix_data, line_cnt}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

`ifndef TEST_PATTERN_EN
    // Table: one frame + one line per vector
    for (int v = 0; v < 7; v++) begin
      got.delete();
      pix_ready = 1'b1;
      frame(vecs[v].key);
      key = vecs[v].key_mid;
      check("line_cnt_after_frame", line_cnt, 0);
      run_line(vecs[v].nbits, vecs[v].pat);
      end_line();
      check("byte_count", got.size(), vecs[v].nexp);
      if (got.size() > 0) check("byte0", got[0], vecs[v].e0);
      if (vecs[v].nexp > 1 && got.size() > 1) check("byte1", got[1], vecs[v].e1);
      check("line_cnt_after_line", line_cnt, 1);
      check("valid_idle", pix_valid, 0);
    end

    // Backpressure: first byte held, second dropped, overflow cleared by frame
    got.delete();
    frame(2'd0);
    pix_ready = 1'b0;
    run_line(16, 16'hFFFF);
    repeat (6) @(negedge clk);
    check("stall_valid", pix_valid, 1);
    check("stall_data", pix_data, 8'hFF);
    check("stall_overflow", overflow, 1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (pix_valid !== 1'b1 || pix_data !== 8'hFF) bad++;
    end
    check("stall_stable", bad, 0);
    end_line();
    pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_delivered", got.size(), 1);
    if (got.size() > 0) check("stall_byte", got[0], 8'hFF);
    check("overflow_sticky", overflow, 1);
    frame(2'd0);
    check("overflow_cleared", overflow, 0);

    // Async reset mid-line with a byte pending
    got.delete();
    pix_ready = 1'b1;
    run_line(4, 16'h000F);
    end_line();
    check("pre_reset_byte", (got.size() == 1) ? got[0] : 8'h00, 8'hF0);
    pix_ready = 1'b0;
    run_line(16, 16'hFFFF);
    repeat (6) @(negedge clk);
    check("pre_reset_state", {pix_valid, overflow, line_cnt}, {1'b1, 1'b1, 10'd1});
    #2 rst_n = 1'b0;
    #1 check("reset_async", {pix_valid, frame_start, overflow, pix_data, line_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tb_sel = 2'd0;
    got.delete();
    pix_ready = 1'b1;
    rpi_color = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rpi_h_sync = (c >= 20);
      if (pix_valid || frame_start || line_cnt != 0) bad++;
    end
    check("post_reset_quiet", bad + got.size(), 0);
    frame(2'd0);
    got.delete();
    run_line(8, 16'h00C3);
    end_line();
    check("recover_count", got.size(), 1);
    if (got.size() > 0) check("recover_byte", got[0], 8'hC3);
`else
    // Checkerboard: line 0 gives 00,FF; line 8 gives FF,00
    got.delete();
    frame(2'd0);
    run_line(16, 16'h0000);
    end_line();
    check("tp_l0_count", got.size(), 2);
    if (got.size() > 1) begin
      check("tp_l0_b0", got[0], 8'h00);
      check("tp_l0_b1", got[1], 8'hFF);
    end
    for (int l = 1; l < 8; l++) begin
      run_line(1, 16'h0000);
      end_line();
    end
    check("tp_line_cnt", line_cnt, 8);
    got.delete();
    run_line(16, 16'h0000);
    end_line();
    check("tp_l8_count", got.size(), 2);
    if (got.size() > 1) begin
      check("tp_l8_b0", got[0], 8'hFF);
      check("tp_l8_b1", got[1], 8'h00);
    end
    check("tp_line_cnt_9", line_cnt, 9);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
